// File: rtl/fmul_arbiter_if.sv
// fmul_arbiter_if: bundles the requester channels and the shared fmul
// operand/result lines of fmul_arbiter.
// slave  : the arbiter side.
// master : the requesters plus the fmul instance.
// The NREQ given to this interface must match the NREQ of the arbiter.
interface fmul_arbiter_if #(
    parameter int NREQ = 2
);
    // Request channels, one valid/ready pair per requester.
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [32*NREQ-1:0]   req_src;
    logic [32*NREQ-1:0]   req_sink;

    // Response channels, one valid/ready pair per requester.
    logic [NREQ-1:0]      resp_valid;
    logic [NREQ-1:0]      resp_ready;
    logic [32*NREQ-1:0]   resp_dest;
    logic [NREQ-1:0]      resp_ovf;
    logic [NREQ-1:0]      resp_udf;

    // Shared multiplier.
    logic [31:0]          fmul_src;
    logic [31:0]          fmul_sink;
    logic [31:0]          fmul_dest;
    logic                 fmul_ovf;
    logic                 fmul_udf;

    modport slave (
        input  req_valid, req_src, req_sink, resp_ready,
        input  fmul_dest, fmul_ovf, fmul_udf,
        output req_ready, resp_valid, resp_dest, resp_ovf, resp_udf,
        output fmul_src, fmul_sink
    );

    modport master (
        output req_valid, req_src, req_sink, resp_ready,
        output fmul_dest, fmul_ovf, fmul_udf,
        input  req_ready, resp_valid, resp_dest, resp_ovf, resp_udf,
        input  fmul_src, fmul_sink
    );
endinterface

// File: rtl/fmul_arbiter.sv
// fmul_arbiter: shares one pipelined fmul unit between NREQ requesters.
// Each requester may have at most one operation outstanding.
// A tag pipeline, LAT stages deep, follows every issued operation so that
// the product can be steered into the owning requester's result register.
// Optional build macro: FMUL_ARB_FIXED_PRIO_EN
//   defined   -> fixed priority, lowest eligible index wins (no pointer).
//   undefined -> round-robin starting at a rotating pointer.
// rst is synchronous and active-high.
module fmul_arbiter #(
    parameter int NREQ = 2,
    parameter int LAT  = 2
) (
    input  logic          clk,
    input  logic          rst,
    fmul_arbiter_if.slave bus
);
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef logic [ID_W-1:0] id_t;

    // One tag pipeline slot: whether an operation occupies it and for whom.
    typedef struct packed {
        logic valid;
        id_t  id;
    } tag_t;

    logic [NREQ-1:0] busy_q;
    logic [NREQ-1:0] eligible;
    logic            pick_any;
    id_t             pick_id;
    logic            grant_any;
    id_t             grant_id;
    logic [NREQ-1:0] grant_vec;

    tag_t            tag_q [LAT];
    tag_t            last_tag;
    logic [NREQ-1:0] capture_vec;

    logic [NREQ-1:0] resp_valid_q;
    logic [NREQ-1:0] resp_fire;
    logic [31:0]     dest_q [NREQ];
    logic [NREQ-1:0] ovf_q;
    logic [NREQ-1:0] udf_q;

    // A requester with a result still pending can never be granted again,
    // which is what protects its result register from being overwritten.
    assign eligible  = bus.req_valid & ~busy_q;
    assign resp_fire = resp_valid_q & bus.resp_ready;

`ifdef FMUL_ARB_FIXED_PRIO_EN

    // Fixed priority: scan downwards so the lowest eligible index is kept.
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        pick_any = 1'b0;
        pick_id  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                pick_any = 1'b1;
                pick_id  = id_t'(i);
            end
        end
    end

`else

    id_t ptr_q;

    // Index offset positions past base, wrapping modulo NREQ.
    function automatic id_t rr_index(input id_t base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end
        return id_t'(sum);
    endfunction

    // Round-robin: scan offsets downwards so the candidate closest to ptr
    // is the one kept.
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        pick_any = 1'b0;
        pick_id  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (eligible[rr_index(ptr_q, i)]) begin
                pick_any = 1'b1;
                pick_id  = rr_index(ptr_q, i);
            end
        end
    end

    // Priority pointer: moves just past the winner, holds when idle.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples its inputs from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (grant_any) begin
            ptr_q <= rr_index(grant_id, 1);
        end
    end

`endif

    // No grant while reset is asserted, so req_ready and fmul operands
    // read 0 during reset.
    assign grant_any = pick_any & ~rst;
    assign grant_id  = pick_id;

    // One-hot grant, which doubles as the req_ready vector.
    always_comb begin
        grant_vec = '0;
        if (grant_any) begin
            grant_vec[grant_id] = 1'b1;
        end
    end

    assign bus.req_ready = grant_vec;

    // Operand mux towards fmul: the granted requester's operands, else 0.
    always_comb begin
        bus.fmul_src  = '0;
        bus.fmul_sink = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (grant_vec[r]) begin
                bus.fmul_src  = bus.req_src[32*r +: 32];
                bus.fmul_sink = bus.req_sink[32*r +: 32];
            end
        end
    end

    // Tag pipeline: stage 0 loads this cycle's grant; the last stage lines
    // up with fmul_dest. Clearing it on reset discards in-flight products.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= '{valid: grant_any, id: grant_id};
            for (int i = 1; i < LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign last_tag = tag_q[LAT-1];

    // Decode the emerging tag into a one-hot capture strobe.
    always_comb begin
        capture_vec = '0;
        if (last_tag.valid) begin
            capture_vec[last_tag.id] = 1'b1;
        end
    end

    // Outstanding-operation flags: set on grant, cleared on the response
    // handshake. Both cannot hit the same requester in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= (busy_q & ~resp_fire) | grant_vec;
        end
    end

    // Response valid: set on capture, held until the requester consumes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= '0;
        end else begin
            resp_valid_q <= (resp_valid_q & ~resp_fire) | capture_vec;
        end
    end

    // Result registers: load the fmul outputs for the owning requester.
    // NOTE: this register array is reset on purpose, because resp_dest and
    // the flags must read 0 after reset, not stale products.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREQ; r++) begin
                dest_q[r] <= '0;
            end
            ovf_q <= '0;
            udf_q <= '0;
        end else begin
            for (int r = 0; r < NREQ; r++) begin
                if (capture_vec[r]) begin
                    dest_q[r] <= bus.fmul_dest;
                    ovf_q[r]  <= bus.fmul_ovf;
                    udf_q[r]  <= bus.fmul_udf;
                end
            end
        end
    end

    // Pack the per-requester result registers onto the response bus.
    always_comb begin
        bus.resp_dest = '0;
        for (int r = 0; r < NREQ; r++) begin
            bus.resp_dest[32*r +: 32] = dest_q[r];
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_ovf   = ovf_q;
    assign bus.resp_udf   = udf_q;

    // Invariants: grants go only to idle requesters, and a capture never
    // lands on a requester whose previous result is still unconsumed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(grant_any && busy_q[grant_id]))
                else $error("grant issued to a busy requester");
            assert ((capture_vec & resp_valid_q) == '0)
                else $error("capture onto an unconsumed result");
        end
    end

endmodule
